jump_ctrl_ras: RTL and testbench

Registered control-transfer resolution unit for the WISC-SP13 pipeline. It decodes J/JAL/JR/JALR and BEQZ/BNEZ/BLTZ/BGEZ, computes the taken decision and target, and generates link address and flush.
It also maintains a parametrised return-address stack (RAS): push on call, pop-and-check on return through R7.
It sits between decode and fetch, with a one-cycle registered latency.

---
 rtl/jump_ctrl_ras.sv | 90 +++++++++
 tb/tb_jump_ctrl_ras.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl_ras.sv
// jump_ctrl_ras: registered jump/branch resolution with return-address stack and flush generation
module jump_ctrl_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic                     stall,
  input  logic [4:0]               opcode,
  input  logic [WIDTH-1:0]         pc,
  input  logic [10:0]              disp11,
  input  logic [7:0]               imm8,
  input  logic [WIDTH-1:0]         rs_val,
  input  logic                     rs_is_r7,
  output logic                     out_valid,
  output logic                     take,
  output logic [WIDTH-1:0]         target,
  output logic                     link_en,
  output logic [WIDTH-1:0]         link_addr,
  output logic                     ras_hit,
  output logic                     ras_mispredict,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   ras_count,
  output logic                     ras_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] sp;
  logic [FW-1:0] fcnt;
  logic [WIDTH-1:0] pc2, sext8, sext11, target_c, top;
  logic acc, jmp, br, link, br_take, take_c, push, pop, empty, full, match;
  assign flush   = fcnt != '0;
  assign acc     = valid_in & ~stall & ~flush;
  assign pc2     = pc + WIDTH'(2);
  assign sext8   = {{(WIDTH-8){imm8[7]}}, imm8};
  assign sext11  = {{(WIDTH-11){disp11[10]}}, disp11};
  assign jmp     = opcode[4:2] == 3'b001;
  assign br      = opcode[4:2] == 3'b011;
  assign link    = jmp & opcode[1];
  // opcode[1:0] selects EQZ / NEZ / LTZ / GEZ within the branch group
  assign br_take = opcode[1] ? (rs_val[WIDTH-1] ^ opcode[0]) : ((rs_val == '0) ^ opcode[0]);
  assign take_c  = jmp | (br & br_take);
  assign target_c = jmp ? (opcode[0] ? rs_val + sext8 : pc2 + sext11) : br ? pc2 + sext8 : pc2;
  assign push    = acc & link;
  assign pop     = acc & jmp & opcode[0] & ~opcode[1] & rs_is_r7;
  assign top     = mem[sp - AW'(1)];
  assign empty   = ras_count == '0;
  assign full    = ras_count == CW'(DEPTH);
  assign match   = ~empty & (top == target_c);
  // the stack write pointer wraps, so a push while full lands on the oldest entry
  always_ff @(posedge clk)
    if (push) mem[sp] <= pc2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid      <= 1'b0;
      take           <= 1'b0;
      target         <= '0;
      link_en        <= 1'b0;
      link_addr      <= '0;
      ras_hit        <= 1'b0;
      ras_mispredict <= 1'b0;
      ras_count      <= '0;
      ras_overflow   <= 1'b0;
      sp             <= '0;
      fcnt           <= '0;
    end else if (!stall) begin
      out_valid      <= acc;
      take           <= acc & take_c;
      link_en        <= acc & link;
      ras_hit        <= pop & match;
      ras_mispredict <= pop & ~match;
      if (acc) begin
        target    <= target_c;
        link_addr <= pc2;
      end
      if (push) begin
        sp <= sp + AW'(1);
        if (full) ras_overflow <= 1'b1;
        else ras_count <= ras_count + CW'(1);
      end else if (pop && !empty) begin
        sp        <= sp - AW'(1);
        ras_count <= ras_count - CW'(1);
      end
      fcnt <= (acc & take_c) ? FW'(FLUSH_CYCLES) : flush ? fcnt - FW'(1) : fcnt;
    end
endmodule

// File: tb/tb_jump_ctrl_ras.sv
// tb_jump_ctrl_ras: directed self-checking bench for jump_ctrl_ras
module tb_jump_ctrl_ras;
  localparam logic [4:0] J = 5'b00100, JR = 5'b00101, JAL = 5'b00110, JALR = 5'b00111;
  localparam logic [4:0] BEQZ = 5'b01100, BNEZ = 5'b01101, BLTZ = 5'b01110, BGEZ = 5'b01111;
  logic clk = 0, rst = 0, valid_in = 0, stall = 0, rs_is_r7 = 0;
  logic [4:0] opcode = 0;
  logic [15:0] pc = 0, rs_val = 0;
  logic [10:0] disp11 = 0;
  logic [7:0] imm8 = 0;
  logic out_valid, take, link_en, ras_hit, ras_mispredict, flush, ras_overflow;
  logic [15:0] target, link_addr;
  logic [2:0] ras_count;
  int checks = 0, failures = 0;

  jump_ctrl_ras dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .opcode(opcode), .pc(pc),
    .disp11(disp11), .imm8(imm8), .rs_val(rs_val), .rs_is_r7(rs_is_r7),
    .out_valid(out_valid), .take(take), .target(target), .link_en(link_en),
    .link_addr(link_addr), .ras_hit(ras_hit), .ras_mispredict(ras_mispredict),
    .flush(flush), .ras_count(ras_count), .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [4:0] op, input logic [15:0] p, input logic [10:0] d,
                     input logic [7:0] i, input logic [15:0] rs, input logic r7);
    opcode = op; pc = p; disp11 = d; imm8 = i; rs_val = rs; rs_is_r7 = r7; valid_in = 1;
    tick();
    valid_in = 0;
  endtask

  task automatic idle2();
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_count", ras_count, 0);
    chk("rst_target", target, 0);
    chk("rst_ovf", ras_overflow, 0);
    rst = 1;
    // JAL then squashed inputs during flush
    run(JAL, 16'h0100, 11'h7FE, 8'h00, 16'h0, 0);
    chk("jal_valid", out_valid, 1);
    chk("jal_take", take, 1);
    chk("jal_target", target, 16'h0100);
    chk("jal_link_en", link_en, 1);
    chk("jal_link_addr", link_addr, 16'h0102);
    chk("jal_count", ras_count, 1);
    chk("jal_flush", flush, 1);
    opcode = J; pc = 16'h0500; valid_in = 1;
    tick();
    chk("sq1_valid", out_valid, 0);
    chk("sq1_flush", flush, 1);
    tick();
    chk("sq2_valid", out_valid, 0);
    chk("sq2_flush", flush, 0);
    chk("sq2_count", ras_count, 1);
    valid_in = 0;
    // returns through R7
    run(JR, 16'h0, 11'h0, 8'h00, 16'h0102, 1);
    chk("ret_target", target, 16'h0102);
    chk("ret_hit", ras_hit, 1);
    chk("ret_mis", ras_mispredict, 0);
    chk("ret_count", ras_count, 0);
    chk("ret_link_en", link_en, 0);
    idle2();
    run(JR, 16'h0, 11'h0, 8'h00, 16'h0200, 1);
    chk("ret_empty_mis", ras_mispredict, 1);
    chk("ret_empty_hit", ras_hit, 0);
    chk("ret_empty_count", ras_count, 0);
    idle2();
    // branches
    run(BLTZ, 16'h0200, 11'h0, 8'h10, 16'h8000, 0);
    chk("bltz_take", take, 1);
    chk("bltz_target", target, 16'h0212);
    idle2();
    run(BGEZ, 16'h0200, 11'h0, 8'h10, 16'h8000, 0);
    chk("bgez_valid", out_valid, 1);
    chk("bgez_take", take, 0);
    chk("bgez_target", target, 16'h0212);
    chk("bgez_flush", flush, 0);
    run(BEQZ, 16'hFFFE, 11'h0, 8'h04, 16'h0000, 0);
    chk("beqz_take", take, 1);
    chk("beqz_target", target, 16'h0004);
    chk("beqz_link_addr", link_addr, 16'h0000);
    idle2();
    run(BNEZ, 16'h0300, 11'h0, 8'hF0, 16'h0000, 0);
    chk("bnez_take", take, 0);
    chk("bnez_target", target, 16'h02F2);
    run(5'b00000, 16'h0300, 11'h0, 8'h00, 16'h0, 1);
    chk("other_take", take, 0);
    chk("other_target", target, 16'h0302);
    chk("other_link_en", link_en, 0);
    chk("other_hit", ras_hit, 0);
    // overflow: five calls into a 4-deep stack
    for (int k = 1; k <= 5; k++) begin
      run(JAL, 16'(k * 16), 11'h0, 8'h00, 16'h0, 0);
      chk("ovf_target", target, 32'(k * 16 + 2));
      chk("ovf_count", ras_count, (k > 4) ? 4 : k);
      chk("ovf_flag", ras_overflow, (k > 4) ? 1 : 0);
      idle2();
    end
    for (int j = 0; j < 4; j++) begin
      run(JR, 16'h0, 11'h0, 8'h00, 16'(16'h0052 - 16'(j * 16)), 1);
      chk("pop_hit", ras_hit, 1);
      chk("pop_count", ras_count, 3 - j);
      idle2();
    end
    run(JR, 16'h0, 11'h0, 8'h00, 16'h0012, 1);
    chk("pop5_mis", ras_mispredict, 1);
    chk("pop5_hit", ras_hit, 0);
    chk("pop5_count", ras_count, 0);
    chk("ovf_sticky", ras_overflow, 1);
    idle2();
    // JALR pushes and never pops
    run(JALR, 16'h0600, 11'h0, 8'hFE, 16'h0300, 1);
    chk("jalr_target", target, 16'h02FE);
    chk("jalr_link_en", link_en, 1);
    chk("jalr_link_addr", link_addr, 16'h0602);
    chk("jalr_hit", ras_hit, 0);
    chk("jalr_mis", ras_mispredict, 0);
    chk("jalr_count", ras_count, 1);
    idle2();
    // stall freezes the flush
    run(J, 16'h0400, 11'h010, 8'h00, 16'h0, 0);
    chk("j_target", target, 16'h0412);
    stall = 1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_flush", flush, 1);
      chk("stall_valid", out_valid, 1);
      chk("stall_target", target, 16'h0412);
    end
    stall = 0;
    tick();
    chk("unstall_flush1", flush, 1);
    chk("unstall_valid", out_valid, 0);
    tick();
    chk("unstall_flush0", flush, 0);
    // async reset mid-flush
    run(J, 16'h0700, 11'h000, 8'h00, 16'h0, 0);
    chk("pre_rst_flush", flush, 1);
    #2;
    rst = 0;
    #1;
    chk("arst_flush", flush, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_count", ras_count, 0);
    chk("arst_target", target, 0);
    chk("arst_ovf", ras_overflow, 0);
    @(negedge clk);
    rst = 1;
    run(JAL, 16'h0800, 11'h002, 8'h00, 16'h0, 0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_target", target, 16'h0804);
    chk("post_rst_count", ras_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
